// File: rtl/drp_arbiter.sv
// Round-robin arbiter giving two requesters access to a single DRP port, one transaction at a time.
// Define DRP_ARB_TIMEOUT_EN to compile in the WAIT timeout (abort after TIMEOUT_CYC cycles).
module drp_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_we,
  input  logic [13:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [1:0]  req_ack,
  output logic [1:0]  req_done,
  output logic [1:0]  req_err,
  output logic [15:0] req_rdata,
  output logic        drp_rd_en,
  output logic        drp_wr_en,
  output logic [6:0]  drp_addr,
  output logic [15:0] drp_wr_data,
  input  logic [15:0] drp_rd_data,
  input  logic        drp_data_rdy
);

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          win_q, win_d;
  logic          prio_q, prio_d;
  logic [1:0]    ack_q, ack_d;
  logic [1:0]    done_q, done_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rd_en_q, rd_en_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          grant_c;

  // prio_q names the requester that wins a tie; a lone requester always wins.
  assign grant_c = (req_valid == 2'b11) ? prio_q : req_valid[1];

`ifdef DRP_ARB_TIMEOUT_EN
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    err_q, err_d;
  logic          timeout_c;

  assign timeout_c = (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign req_err = err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^CW'(TIMEOUT_CYC);
  assign req_err            = 2'b00;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; drp_data_rdy only matters in WAIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) state_d = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (drp_data_rdy) state_d = ST_IDLE;
`ifdef DRP_ARB_TIMEOUT_EN
        else if (timeout_c) state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: computes the next value of every registered output
  always_comb begin
    win_d   = win_q;
    prio_d  = prio_q;
    ack_d   = '0;
    done_d  = '0;
    rdata_d = rdata_q;
    rd_en_d = 1'b0;
    wr_en_d = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
`ifdef DRP_ARB_TIMEOUT_EN
    err_d   = '0;
    cnt_d   = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          win_d          = grant_c;
          prio_d         = ~grant_c;
          ack_d[grant_c] = 1'b1;
          rd_en_d        = ~req_we[grant_c];
          wr_en_d        = req_we[grant_c];
          addr_d         = grant_c ? req_addr[13:7]   : req_addr[6:0];
          wdata_d        = grant_c ? req_wdata[31:16] : req_wdata[15:0];
        end
      end
      ST_WAIT: begin
        if (drp_data_rdy) begin
          done_d[win_q] = 1'b1;
          rdata_d       = drp_rd_data;
        end
`ifdef DRP_ARB_TIMEOUT_EN
        else if (timeout_c) begin
          done_d[win_q] = 1'b1;
          err_d[win_q]  = 1'b1;
          rdata_d       = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q   <= 1'b0;
      prio_q  <= 1'b0;
      ack_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      win_q   <= win_d;
      prio_q  <= prio_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign req_ack     = ack_q;
  assign req_done    = done_q;
  assign req_rdata   = rdata_q;
  assign drp_rd_en   = rd_en_q;
  assign drp_wr_en   = wr_en_q;
  assign drp_addr    = addr_q;
  assign drp_wr_data = wdata_q;

endmodule

// File: tb/tb_drp_arbiter.sv
// Bench for drp_arbiter: transaction-level reference model compared every cycle, plus directed literal checks.
// Exercises the timeout path when DRP_ARB_TIMEOUT_EN is defined, the endless WAIT otherwise.
module tb_drp_arbiter;

  localparam int unsigned TO = 8;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_ack;
  logic [1:0]  req_done;
  logic [1:0]  req_err;
  logic [15:0] req_rdata;
  logic        drp_rd_en;
  logic        drp_wr_en;
  logic [6:0]  drp_addr;
  logic [15:0] drp_wr_data;
  logic [15:0] drp_rd_data;
  logic        drp_data_rdy;

  int n_chk  = 0;
  int n_pass = 0;

  drp_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ack      (req_ack),
    .req_done     (req_done),
    .req_err      (req_err),
    .req_rdata    (req_rdata),
    .drp_rd_en    (drp_rd_en),
    .drp_wr_en    (drp_wr_en),
    .drp_addr     (drp_addr),
    .drp_wr_data  (drp_wr_data),
    .drp_rd_data  (drp_rd_data),
    .drp_data_rdy (drp_data_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one outstanding transaction, tracked by its age in clock edges since the grant
  logic        m_busy;
  int unsigned m_age;
  logic        m_owner;
  logic        m_prio;
  logic        m_g;
  logic [1:0]  m_own_oh;
  logic [1:0]  e_ack, e_done, e_err;
  logic [15:0] e_rdata, e_wd;
  logic        e_rd, e_wr;
  logic [6:0]  e_addr;

  assign m_g      = (req_valid == 2'b11) ? m_prio : req_valid[1];
  assign m_own_oh = m_owner ? 2'b10 : 2'b01;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_age <= 0; m_owner <= 1'b0; m_prio <= 1'b0;
      e_ack <= '0; e_done <= '0; e_err <= '0; e_rdata <= '0;
      e_rd <= 1'b0; e_wr <= 1'b0; e_addr <= '0; e_wd <= '0;
    end else begin
      e_ack <= '0; e_done <= '0; e_err <= '0;
      e_rd <= 1'b0; e_wr <= 1'b0; e_addr <= '0; e_wd <= '0;
      if (m_busy) begin
        m_age <= m_age + 1;
        if (m_age >= 1 && drp_data_rdy) begin
          e_done <= m_own_oh; e_rdata <= drp_rd_data; m_busy <= 1'b0;
        end
`ifdef DRP_ARB_TIMEOUT_EN
        else if (m_age == TO) begin
          e_done <= m_own_oh; e_err <= m_own_oh; e_rdata <= '0; m_busy <= 1'b0;
        end
`endif
      end else if (req_valid != 2'b00) begin
        m_busy  <= 1'b1;
        m_age   <= 0;
        m_owner <= m_g;
        m_prio  <= ~m_g;
        e_ack   <= m_g ? 2'b10 : 2'b01;
        e_rd    <= ~req_we[m_g];
        e_wr    <= req_we[m_g];
        e_addr  <= m_g ? req_addr[13:7] : req_addr[6:0];
        e_wd    <= m_g ? req_wdata[31:16] : req_wdata[15:0];
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("cyc_ack",   32'(req_ack),     32'(e_ack));
    chk("cyc_done",  32'(req_done),    32'(e_done));
    chk("cyc_err",   32'(req_err),     32'(e_err));
    chk("cyc_rdata", 32'(req_rdata),   32'(e_rdata));
    chk("cyc_rd_en", 32'(drp_rd_en),   32'(e_rd));
    chk("cyc_wr_en", 32'(drp_wr_en),   32'(e_wr));
    chk("cyc_addr",  32'(drp_addr),    32'(e_addr));
    chk("cyc_wdata", 32'(drp_wr_data), 32'(e_wd));
  end

  task automatic wait_ack(output logic [1:0] a, output int n);
    a = 2'b00;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (req_ack != 2'b00) begin
        a = req_ack;
        break;
      end
    end
    if (a == 2'b00) begin
      n_chk++;
      $display("FAIL ack_wait: no req_ack within 20 cycles at %0t", $time);
    end
  endtask

  // Raise drp_data_rdy dly cycles from now for one cycle; returns in the req_done cycle
  task automatic respond(input int dly, input logic [15:0] d);
    repeat (dly) @(negedge clk);
    drp_data_rdy = 1'b1;
    drp_rd_data  = d;
    @(negedge clk);
    drp_data_rdy = 1'b0;
    drp_rd_data  = 16'h0000;
  endtask

  logic [1:0] a;
  int         n;
  logic [1:0] rr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    rst_n = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    drp_rd_data = '0; drp_data_rdy = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack",   32'(req_ack),   32'h0);
    chk("rst_rdata", 32'(req_rdata), 32'h0);
    chk("rst_rd_en", 32'(drp_rd_en), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read from requester 0
    req_valid = 2'b01; req_we = 2'b00; req_addr = 14'h0003;
    wait_ack(a, n);
    chk("rd_ack",   32'(a),         32'h1);
    chk("rd_lat",   32'(n),         32'd1);
    chk("rd_en",    32'(drp_rd_en), 32'h1);
    chk("rd_wr_en", 32'(drp_wr_en), 32'h0);
    chk("rd_addr",  32'(drp_addr),  32'h03);
    req_valid = 2'b00;
    respond(3, 16'h1234);
    chk("rd_done",  32'(req_done),  32'h1);
    chk("rd_rdata", 32'(req_rdata), 32'h1234);
    @(negedge clk);
    chk("rd_done_pulse", 32'(req_done),  32'h0);
    chk("rd_rdata_hold", 32'(req_rdata), 32'h1234);

    // Write from requester 1
    req_valid = 2'b10; req_we = 2'b10; req_addr = {7'h41, 7'h00}; req_wdata = {16'hBEEF, 16'h0000};
    wait_ack(a, n);
    chk("wr_ack",   32'(a),           32'h2);
    chk("wr_en",    32'(drp_wr_en),   32'h1);
    chk("wr_rd_en", 32'(drp_rd_en),   32'h0);
    chk("wr_addr",  32'(drp_addr),    32'h41);
    chk("wr_wdata", 32'(drp_wr_data), 32'hBEEF);
    req_valid = 2'b00;
    @(negedge clk);
    chk("wr_en_one_cycle", 32'(drp_wr_en), 32'h0);
    chk("wr_addr_cleared", 32'(drp_addr),  32'h0);
    respond(1, 16'h5555);
    chk("wr_done",  32'(req_done),  32'h2);
    chk("wr_rdata", 32'(req_rdata), 32'h5555);

    // Contention: both held high, grants alternate with no gap
    req_valid = 2'b11; req_we = 2'b10; req_addr = {7'h20, 7'h10}; req_wdata = {16'hA5A5, 16'h5A5A};
    for (int i = 0; i < 4; i++) begin
      wait_ack(a, n);
      if (i == 3) req_valid = 2'b00;
      chk("rr_grant", 32'(a), 32'(rr_exp[i]));
      if (i > 0) chk("rr_no_gap", 32'(n), 32'd1);
      respond(1 + i, 16'(16'h1111 * (i + 1)));
      chk("rr_done", 32'(req_done), 32'(rr_exp[i]));
    end

    // drp_data_rdy ignored in IDLE and in ISSUE
    drp_data_rdy = 1'b1; drp_rd_data = 16'hDEAD;
    @(negedge clk);
    drp_data_rdy = 1'b0;
    @(negedge clk);
    chk("idle_rdy_ignored", 32'(req_done), 32'h0);
    req_valid = 2'b01; req_we = 2'b00; req_addr = 14'h007F;
    wait_ack(a, n);
    req_valid = 2'b00;
    drp_data_rdy = 1'b1; drp_rd_data = 16'hDEAD;
    @(negedge clk);
    drp_data_rdy = 1'b0;
    chk("issue_rdy_ignored", 32'(req_done), 32'h0);
    respond(1, 16'hCAFE);
    chk("late_done",  32'(req_done),  32'h1);
    chk("late_rdata", 32'(req_rdata), 32'hCAFE);

`ifdef DRP_ARB_TIMEOUT_EN
    // No response: abort after TO WAIT cycles
    req_valid = 2'b01; req_we = 2'b00; req_addr = 14'h0011;
    wait_ack(a, n);
    req_valid = 2'b00;
    n = 0;
    while (n < int'(TO) + 5 && req_done == 2'b00) begin
      @(negedge clk);
      n++;
    end
    chk("to_latency", 32'(n),         32'(TO + 1));
    chk("to_done",    32'(req_done),  32'h1);
    chk("to_err",     32'(req_err),   32'h1);
    chk("to_rdata",   32'(req_rdata), 32'h0);
    req_valid = 2'b10; req_we = 2'b00; req_addr = {7'h12, 7'h00};
    wait_ack(a, n);
    chk("to_next_ack", 32'(a), 32'h2);
    chk("to_next_lat", 32'(n), 32'd1);
    req_valid = 2'b00;
    respond(2, 16'h0F0F);
    chk("to_next_done", 32'(req_done), 32'h2);
    chk("to_next_err",  32'(req_err),  32'h0);
`else
    // No timeout: WAIT persists until the response arrives
    req_valid = 2'b01; req_we = 2'b00; req_addr = 14'h0011;
    wait_ack(a, n);
    req_valid = 2'b00;
    repeat (3 * TO) @(negedge clk);
    chk("nto_still_waiting", 32'(req_done), 32'h0);
    respond(1, 16'h0F0F);
    chk("nto_done",  32'(req_done),  32'h1);
    chk("nto_err",   32'(req_err),   32'h0);
    chk("nto_rdata", 32'(req_rdata), 32'h0F0F);
`endif

    // Reset in WAIT after a requester-0 grant; pointer must return to requester 0
    req_valid = 2'b01; req_we = 2'b00; req_addr = 14'h0005;
    wait_ack(a, n);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_done",  32'(req_done),  32'h0);
    chk("rstw_rdata", 32'(req_rdata), 32'h0);
    chk("rstw_ack",   32'(req_ack),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drp_data_rdy = 1'b1; drp_rd_data = 16'hABCD;
    @(negedge clk);
    drp_data_rdy = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rstw_stray_done",  32'(req_done),  32'h0);
      chk("rstw_stray_rdata", 32'(req_rdata), 32'h0);
    end
    req_valid = 2'b11; req_we = 2'b00; req_addr = {7'h22, 7'h21};
    wait_ack(a, n);
    req_valid = 2'b10;
    chk("rstw_first_grant", 32'(a), 32'h1);
    respond(1, 16'h7777);
    chk("rstw_done0", 32'(req_done), 32'h1);
    wait_ack(a, n);
    req_valid = 2'b00;
    chk("rstw_second_grant", 32'(a), 32'h2);
    chk("rstw_second_lat",   32'(n), 32'd1);
    respond(2, 16'h8888);
    chk("rstw_done1",  32'(req_done),  32'h2);
    chk("rstw_rdata1", 32'(req_rdata), 32'h8888);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
